// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_serial_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int CHUNK = 4;

  function automatic int nchunks(input int width);
    return (width + CHUNK - 1) / CHUNK;
  endfunction

endpackage

// File: rtl/sub_nibble.sv
// 4-bit carry-lookahead adder computing a + ~b + cin, with the carry-out
// picked at a selectable bit position so a short final chunk can be handled.
module sub_nibble (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic [2:0] i_width,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & ~i_b;
  assign w_p = i_a ^ ~i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ w_c[3:0];

  always_comb begin
    case (i_width)
      3'd1:    o_cout = w_c[1];
      3'd2:    o_cout = w_c[2];
      3'd3:    o_cout = w_c[3];
      default: o_cout = w_c[4];
    endcase
  end

endmodule

// File: rtl/sub_serial.sv
// Digit-serial subtractor D = A - B - bin, one 4-bit chunk per clock, LSB first,
// with valid/ready handshakes on operand and result sides.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int Q  = nchunks(WIDTH);
  localparam int R  = WIDTH - (Q - 1) * CHUNK;
  localparam int QW = Q * CHUNK;
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] LAST = CW'(Q - 1);
  localparam logic [2:0]    R3   = 3'(R);

  sub_state_t r_state, w_state_next;

  logic [QW-1:0]    r_a, r_b, r_acc, w_acc_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_d;
  logic             r_bout, r_ovf, r_zero;
  logic             w_last;
  logic [2:0]       w_width;
  logic [3:0]       w_sum;
  logic             w_cout;

  assign w_last  = (r_cnt == LAST);
  assign w_width = w_last ? R3 : 3'd4;

  sub_nibble u_nibble (
    .i_a     (r_a[r_cnt*CHUNK +: CHUNK]),
    .i_b     (r_b[r_cnt*CHUNK +: CHUNK]),
    .i_cin   (r_carry),
    .i_width (w_width),
    .o_sum   (w_sum),
    .o_cout  (w_cout)
  );

  // Accumulator including the chunk being computed this cycle, so the final
  // result can be loaded on the same edge that finishes the last chunk.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_cnt*CHUNK +: CHUNK] = w_sum;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_state_next = RUN;
      end
      RUN:  if (w_last) w_state_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_valid) begin
          r_a     <= QW'(i_a);
          r_b     <= QW'(i_b);
          r_acc   <= '0;
          r_cnt   <= '0;
          r_carry <= ~i_bin;
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          if (w_last) begin
            r_d    <= w_acc_next[WIDTH-1:0];
            r_bout <= ~w_cout;
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                      (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
            r_zero <= (w_acc_next[WIDTH-1:0] == '0);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_d    = r_d;
  assign o_bout = r_bout;
  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial at WIDTH=8 and WIDTH=5 with hand-computed results.
module tb_sub_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       v8 = 0, ir8 = 0, bin8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       rdy8, ov8, bout8, ovf8, zero8;
  logic [7:0] d8;

  // WIDTH=5 instance
  logic       v5 = 0, ir5 = 0, bin5 = 0;
  logic [4:0] a5 = 0, b5 = 0;
  logic       rdy5, ov5, bout5, ovf5, zero5;
  logic [4:0] d5;

  sub_serial #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8),
    .i_a(a8), .i_b(b8), .i_bin(bin8), .o_valid(ov8), .i_ready(ir8),
    .o_d(d8), .o_bout(bout8), .o_ovf(ovf8), .o_zero(zero8)
  );

  sub_serial #(.WIDTH(5)) u5 (
    .i_clk(clk), .i_rst(rst), .i_valid(v5), .o_ready(rdy5),
    .i_a(a5), .i_b(b5), .i_bin(bin5), .o_valid(ov5), .i_ready(ir5),
    .o_d(d5), .o_bout(bout5), .o_ovf(ovf5), .o_zero(zero5)
  );

  int n_vec = 0;
  int n_err = 0;

  // Selects which instance the op task drives and observes.
  bit         cur = 0;
  logic       s_rdy, s_ov, s_bout, s_ovf, s_zero;
  logic [7:0] s_d;
  always_comb begin
    s_rdy  = cur ? rdy5  : rdy8;
    s_ov   = cur ? ov5   : ov8;
    s_bout = cur ? bout5 : bout8;
    s_ovf  = cur ? ovf5  : ovf8;
    s_zero = cur ? zero5 : zero8;
    s_d    = cur ? {3'b000, d5} : d8;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit sel, input bit v, input logic [7:0] a,
                        input logic [7:0] b, input bit bin);
    if (sel) begin v5 = v; a5 = a[4:0]; b5 = b[4:0]; bin5 = bin; end
    else     begin v8 = v; a8 = a;      b8 = b;      bin8 = bin; end
  endtask

  task automatic set_ir(input bit sel, input bit r);
    if (sel) ir5 = r; else ir8 = r;
  endtask

  // Full operation: accept, two RUN cycles (Q=2 for both widths), DONE, release.
  task automatic op(input string tag, input bit sel, input logic [7:0] a,
                    input logic [7:0] b, input bit bin, input logic [7:0] ed,
                    input bit eb, input bit eo, input bit ez);
    cur = sel;
    set_in(sel, 1'b1, a, b, bin);
    #1;
    chk({tag, ".ready_idle"}, {7'd0, s_rdy}, 8'd1);
    tick();
    set_in(sel, 1'b0, ~a, ~b, ~bin);
    chk({tag, ".ready_run"}, {7'd0, s_rdy}, 8'd0);
    chk({tag, ".valid_run0"}, {7'd0, s_ov}, 8'd0);
    tick();
    chk({tag, ".valid_run1"}, {7'd0, s_ov}, 8'd0);
    tick();
    chk({tag, ".valid_done"}, {7'd0, s_ov}, 8'd1);
    chk({tag, ".d"}, s_d, ed);
    chk({tag, ".bout"}, {7'd0, s_bout}, {7'd0, eb});
    chk({tag, ".ovf"}, {7'd0, s_ovf}, {7'd0, eo});
    chk({tag, ".zero"}, {7'd0, s_zero}, {7'd0, ez});
    set_ir(sel, 1'b1);
    tick();
    set_ir(sel, 1'b0);
    chk({tag, ".valid_drop"}, {7'd0, s_ov}, 8'd0);
    chk({tag, ".ready_back"}, {7'd0, s_rdy}, 8'd1);
    chk({tag, ".d_hold"}, s_d, ed);
    $display("op %s: a=%0h b=%0h bin=%0d -> d=%0h bout=%0d ovf=%0d zero=%0d",
             tag, a, b, bin, s_d, s_bout, s_ovf, s_zero);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst.ready", {7'd0, rdy8}, 8'd1);
    chk("rst.valid", {7'd0, ov8}, 8'd0);
    chk("rst.d", d8, 8'h00);
    chk("rst.flags", {5'd0, bout8, ovf8, zero8}, 8'd0);
    chk("rst.ready5", {7'd0, rdy5}, 8'd1);

    op("sub05_03", 0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    op("sub00_01", 0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    op("sub80_01", 0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op("sub10_0F_b", 0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    op("sub7F_FF", 0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    op("w5_10_11", 1, 8'h10, 8'h11, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0);
    op("w5_0F_10", 1, 8'h0F, 8'h10, 1'b0, 8'h1F, 1'b1, 1'b1, 1'b0);
    op("w5_1F_00", 1, 8'h1F, 8'h00, 1'b1, 8'h1E, 1'b0, 1'b0, 1'b0);

    // Backpressure: result 0x22 held in DONE while a new request waits.
    cur = 0;
    set_in(0, 1'b1, 8'h33, 8'h11, 1'b0);
    tick();
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    set_in(0, 1'b1, 8'h99, 8'h09, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {7'd0, ov8}, 8'd1);
      chk("bp.ready", {7'd0, rdy8}, 8'd0);
      chk("bp.d", d8, 8'h22);
      tick();
    end
    ir8 = 1'b1;
    tick();
    ir8 = 1'b0;
    chk("bp.valid_drop", {7'd0, ov8}, 8'd0);
    chk("bp.ready_rise", {7'd0, rdy8}, 8'd1);
    tick();
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("bp.accepted", {7'd0, rdy8}, 8'd0);
    tick();
    tick();
    chk("bp.valid2", {7'd0, ov8}, 8'd1);
    chk("bp.d2", d8, 8'h90);
    chk("bp.flags2", {5'd0, bout8, ovf8, zero8}, 8'd0);
    $display("op backpressure: d=%0h", d8);
    ir8 = 1'b1;
    tick();
    ir8 = 1'b0;

    // Reset in the middle of RUN discards the operation.
    set_in(0, 1'b1, 8'h05, 8'h03, 1'b0);
    tick();
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.ready", {7'd0, rdy8}, 8'd1);
    chk("midrst.valid", {7'd0, ov8}, 8'd0);
    chk("midrst.d", d8, 8'h00);
    chk("midrst.flags", {5'd0, bout8, ovf8, zero8}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk("midrst.no_valid", {7'd0, ov8}, 8'd0);
      tick();
    end
    $display("op midrun_reset: ready=%0d valid=%0d d=%0h", rdy8, ov8, d8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Multi-cycle, digit-serial subtractor computing D = A - B - i_bin.
- Processes 4-bit chunks LSB-first, one chunk per clock, using the same nibble partitioning as the team's flexible-width adder.
- Valid/ready handshake on both sides.
- Used where area matters more than latency, e.g. pointer-difference and counter-compare paths next to the combinational adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- Derived localparam Q = (WIDTH+3)/4, the number of chunks.
- Derived localparam R = WIDTH - (Q-1)*4, the width of the last chunk (1..4).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  operands present.
- o_ready  out  1  block can accept operands.
- i_a  in  WIDTH  minuend.
- i_b  in  WIDTH  subtrahend.
- i_bin  in  1  borrow in.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts result.
- o_d  out  WIDTH  difference, modulo 2^WIDTH.
- o_bout  out  1  borrow out; 1 when A < B + bin (unsigned).
- o_ovf  out  1  two's-complement overflow.
- o_zero  out  1  o_d == 0.

Behaviour:
- Single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state IDLE, o_valid=0, o_ready=1 (decoded from IDLE), o_d=0, o_bout=0, o_ovf=0, o_zero=0. Chunk counter and accumulator cleared.
- Reset wins over every other event. Reset mid-RUN or mid-DONE discards the operation: no o_valid pulse, and the accepted operands are lost.
- FSM states: IDLE, RUN, DONE.
  - IDLE: o_ready=1. On an edge with i_valid=1, latch i_a, i_b and i_bin. Set cnt=0, carry=~i_bin, go to RUN.
  - RUN: o_ready=0, o_valid=0. Each edge computes chunk cnt as a_chunk + ~b_chunk + carry.
    - Store the sum bits in accumulator[cnt*4 +: 4].
    - carry takes the chunk carry-out.
    - For the last chunk (cnt==Q-1) only R bits are used, and carry is taken at bit R.
    - When cnt==Q-1, go to DONE and load the output registers.
    - Otherwise cnt++.
  - DONE: o_valid=1, o_ready=0. Outputs hold stable. On an edge with i_ready=1, go to IDLE; o_valid drops and o_ready rises in the next cycle.
- Output register load at RUN->DONE:
  - o_d = final accumulator.
  - o_bout = ~final carry.
  - o_ovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]).
  - o_zero = (d == 0).
- Latency: accept at edge k, o_valid visible after edge k+Q. Example: WIDTH=8 gives 2 cycles; WIDTH<=4 gives 1 cycle.
- Throughput: one operation per Q+2 cycles minimum. There is no accept in DONE and no back-to-back overlap.
- o_d and the flags change only on RUN->DONE or reset. Between operations they keep the last completed result. The accumulator is internal and is not driven onto o_d.
- i_valid while o_ready=0 is ignored; the producer must hold its request.
- i_a, i_b and i_bin are sampled only at the accept edge; later changes have no effect.
- i_ready while o_valid=0 is ignored.
- WIDTH=1: Q=1, R=1, and ovf reduces to the sign rule on single bits.

Decomposition:
- Package sub_serial_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t
  - localparam CHUNK = 4
  - function nchunks(width) returns (width+3)/4
- One combinational sub-module, sub_nibble:
  - Inputs: 4-bit a, 4-bit b, cin, 3-bit valid-width select.
  - Outputs: 4-bit sum, cout taken at the selected width.
  - Implemented as a CLA on a + ~b.
  - Instantiated once and time-multiplexed by cnt.

Test Plan:
- WIDTH=8, A=0x05, B=0x03, bin=0 -> o_d=0x02, bout=0, ovf=0, zero=0; o_valid exactly 2 cycles after accept.
- WIDTH=8, A=0x00, B=0x01 -> o_d=0xFF, bout=1, ovf=0. Then A=0x80, B=0x01 -> o_d=0x7F, bout=0, ovf=1.
- WIDTH=8, A=0x10, B=0x0F, bin=1 -> o_d=0x00, zero=1, bout=0; exercises the cross-chunk borrow.
- WIDTH=5 (Q=2, R=1), A=0x10, B=0x11 -> o_d=0x1F, bout=1, ovf=0.
- Backpressure:
  - Stimulus: hold i_ready=0 for 5 cycles in DONE while driving i_valid=1 with new operands.
  - Response: outputs stable and o_ready=0. On release, o_valid drops, o_ready rises the next cycle, then the new operands are accepted.
- Reset: assert i_rst for 1 cycle in the middle of RUN -> all outputs at reset values and o_ready=1 next cycle; no o_valid pulse for the aborted operation.
